// File: rtl/fp_align_pkg.sv
// Shared format defaults and derived widths for the FP add/sub operand alignment stage.
package fp_align_pkg;

   localparam int SIZE_EXP_DEF = 8;
   localparam int SIZE_MAN_DEF = 23;

   // Two guard positions plus sticky: beyond this every bit of the small mantissa is sticky.
   function automatic int calc_max_shift(input int size_man);
      return size_man + 3;
   endfunction

   function automatic int calc_shift_w(input int size_man);
      return $clog2(size_man + 4);
   endfunction

   typedef struct packed {
      logic                    sign_a;
      logic                    sign_b;
      logic                    sub;
      logic                    swap;
      logic [SIZE_EXP_DEF-1:0] exp_large;
      logic [SIZE_MAN_DEF-1:0] frac_large;
      logic [SIZE_EXP_DEF-1:0] exp_small;
      logic [SIZE_MAN_DEF-1:0] frac_small;
   } s1_payload_t;

endpackage

// File: rtl/opr_align_swap_cmp.sv
// Unsigned magnitude less-than on packed {exp, frac} fields.
module opr_align_swap_cmp #(
   parameter int SIZE_DATA = 31
) (
   input  logic [SIZE_DATA-1:0] a,
   input  logic [SIZE_DATA-1:0] b,
   output logic                 less
);

   assign less = (a < b);

endmodule

// File: rtl/opr_align_swap.sv
// Two-stage elastic pipeline: magnitude compare/swap, then hidden-bit restore and shift computation.
module opr_align_swap
   import fp_align_pkg::*;
#(
   parameter  int SIZE_EXP  = SIZE_EXP_DEF,
   parameter  int SIZE_MAN  = SIZE_MAN_DEF,
   localparam int SIZE_DATA = 1 + SIZE_EXP + SIZE_MAN,
   localparam int MAX_SHIFT = calc_max_shift(SIZE_MAN),
   localparam int SHIFT_W   = calc_shift_w(SIZE_MAN)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [SIZE_DATA-1:0] i_data_a,
   input  logic [SIZE_DATA-1:0] i_data_b,
   input  logic                 i_sub,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_swap,
   output logic                 o_eff_sub,
   output logic                 o_sign,
   output logic [SIZE_EXP-1:0]  o_exp_large,
   output logic [SIZE_MAN:0]    o_man_large,
   output logic [SIZE_MAN:0]    o_man_small,
   output logic [SHIFT_W-1:0]   o_shift,
   output logic                 o_shift_sat,
   output logic                 o_zero_res
);

   typedef struct packed {
      logic                sign_a;
      logic                sign_b;
      logic                sub;
      logic                swap;
      logic [SIZE_EXP-1:0] exp_large;
      logic [SIZE_MAN-1:0] frac_large;
      logic [SIZE_EXP-1:0] exp_small;
      logic [SIZE_MAN-1:0] frac_small;
   } s1_t;

   typedef struct packed {
      logic                swap;
      logic                eff_sub;
      logic                sign;
      logic [SIZE_EXP-1:0] exp_large;
      logic [SIZE_MAN:0]   man_large;
      logic [SIZE_MAN:0]   man_small;
      logic [SHIFT_W-1:0]  shift;
      logic                shift_sat;
      logic                zero_res;
   } s2_t;

   logic s1_valid_reg;
   logic s2_valid_reg;
   s1_t  s1_reg;
   s1_t  s1_next;
   s2_t  s2_reg;
   s2_t  s2_next;
   logic s1_load;
   logic s2_load;
   logic a_less_b;

   logic [SIZE_EXP-1:0] eff_large;
   logic [SIZE_EXP-1:0] eff_small;
   logic [SIZE_EXP-1:0] exp_diff;
   logic                mag_equal;

   assign s2_load = !s2_valid_reg || i_ready;
   assign o_ready = !s1_valid_reg || s2_load;
   assign s1_load = i_valid && o_ready;

   opr_align_swap_cmp #(
      .SIZE_DATA(SIZE_EXP + SIZE_MAN)
   ) u_cmp (
      .a    (i_data_a[SIZE_DATA-2:0]),
      .b    (i_data_b[SIZE_DATA-2:0]),
      .less (a_less_b)
   );

   // Equal magnitudes keep A as the large operand.
   always_comb begin
      s1_next        = '0;
      s1_next.sign_a = i_data_a[SIZE_DATA-1];
      s1_next.sign_b = i_data_b[SIZE_DATA-1];
      s1_next.sub    = i_sub;
      s1_next.swap   = a_less_b;
      if (a_less_b) begin
         {s1_next.exp_large, s1_next.frac_large} = i_data_b[SIZE_DATA-2:0];
         {s1_next.exp_small, s1_next.frac_small} = i_data_a[SIZE_DATA-2:0];
      end else begin
         {s1_next.exp_large, s1_next.frac_large} = i_data_a[SIZE_DATA-2:0];
         {s1_next.exp_small, s1_next.frac_small} = i_data_b[SIZE_DATA-2:0];
      end
   end

   // Subnormals share the minimum normal exponent, so effective exponents never invert the order.
   always_comb begin
      eff_large = (s1_reg.exp_large == '0) ? SIZE_EXP'(1) : s1_reg.exp_large;
      eff_small = (s1_reg.exp_small == '0) ? SIZE_EXP'(1) : s1_reg.exp_small;
      exp_diff  = eff_large - eff_small;
      mag_equal = ({s1_reg.exp_large, s1_reg.frac_large} == {s1_reg.exp_small, s1_reg.frac_small});

      s2_next           = '0;
      s2_next.swap      = s1_reg.swap;
      s2_next.eff_sub   = s1_reg.sign_a ^ s1_reg.sign_b ^ s1_reg.sub;
      s2_next.zero_res  = mag_equal && s2_next.eff_sub;
      s2_next.sign      = s2_next.zero_res ? 1'b0
                        : (s1_reg.swap ? (s1_reg.sign_b ^ s1_reg.sub) : s1_reg.sign_a);
      s2_next.exp_large = eff_large;
      s2_next.man_large = {(s1_reg.exp_large != '0), s1_reg.frac_large};
      s2_next.man_small = {(s1_reg.exp_small != '0), s1_reg.frac_small};
      s2_next.shift_sat = (32'(exp_diff) > 32'(MAX_SHIFT));
      s2_next.shift     = s2_next.shift_sat ? SHIFT_W'(MAX_SHIFT) : SHIFT_W'(exp_diff);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         s1_reg       <= '0;
         s2_reg       <= '0;
      end else begin
         if (o_ready) s1_valid_reg <= i_valid;
         if (s1_load) s1_reg <= s1_next;
         if (s2_load) s2_valid_reg <= s1_valid_reg;
         if (s2_load && s1_valid_reg) s2_reg <= s2_next;
      end
   end

   assign o_valid     = s2_valid_reg;
   assign o_swap      = s2_reg.swap;
   assign o_eff_sub   = s2_reg.eff_sub;
   assign o_sign      = s2_reg.sign;
   assign o_exp_large = s2_reg.exp_large;
   assign o_man_large = s2_reg.man_large;
   assign o_man_small = s2_reg.man_small;
   assign o_shift     = s2_reg.shift;
   assign o_shift_sat = s2_reg.shift_sat;
   assign o_zero_res  = s2_reg.zero_res;

endmodule
